sv_sound: RTL
=============

Name: sv_sound

Overview:
- Audio generator for the console's sound register window.
- Decodes CPU writes to the square channels (0x2010-0x2017) and the noise channel (0x2028-0x202A).
- Runs two duty-cycle square generators and one LFSR noise generator, then mixes them into unsigned 16-bit left/right samples.
- Sits beside the DMA and LCD register decode in the top level and drives AUDIO_L/AUDIO_R with AUDIO_S=0.

Parameters:
- LEN_DIV, 16384: number of ce ticks per length-counter decrement.
- SAMPLE_SHIFT, 10: left shift applied to the 6-bit mix sum to form the 16-bit output.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- ce  in  1  one-cycle tick at CPU clock rate; all generator timing advances only on ce
- cs  in  1  sound register window selected
- we  in  1  CPU write strobe, valid with cs
- addr  in  6  CPU address[5:0] (offset from 0x2000)
- din  in  8  CPU write data
- audio_l  out  16  unsigned left sample
- audio_r  out  16  unsigned right sample
- active  out  3  {noise, ch2, ch1} channel-running flags

Behaviour:
- Register map; writes take effect the cycle after cs&we, independent of ce. There is no readback.
  - Square 1 at 0x10-0x13, square 2 at 0x14-0x17, offsets relative to the channel base:
    - +0: period[7:0]
    - +1: period[10:8] in din[2:0]
    - +2: ctrl = vol[3:0], duty[5:4] (00=12.5%, 01=25%, 10=50%, 11=75%), L-enable[6], R-enable[7]
    - +3: length; a write loads the length counter and sets active.
  - Noise at 0x28-0x2A:
    - 0x28: vol[3:0], freq sel[7:4]
    - 0x29: length; a write loads the counter and sets active
    - 0x2A: short mode[0], continuous[1], L[2], R[3], enable[4]
  - Other addresses are ignored.
- Square generator:
  - 11-bit down-counter decrements on ce.
  - At 0 it reloads period and advances a 3-bit step counter.
  - Output is high when step < duty length; duty lengths are 1, 2, 4, 6 of 8.
  - A period write is applied at the next reload. Period 0 forces output low and holds the counter.
- Noise generator:
  - 18-bit down-counter, reload value 8<<sel.
  - At 0 the 15-bit LFSR shifts right; feedback = lfsr[0]^lfsr[1] goes into bit14, and also into bit6 when short mode is set.
  - Output = ~lfsr[0].
  - LFSR reset value is 0x7FFF. Writing 0x2A with enable=0 reloads 0x7FFF.
- Length prescaler:
  - A 14-bit counter on ce emits len_tick every LEN_DIV ticks.
  - On len_tick each active channel with nonzero length decrements; on reaching 0, active clears.
  - Noise with continuous=1 never clears active.
  - A length write in the same cycle as len_tick: the write wins.
- Channel output level:
  - Square: vol when active & generator high, else 0.
  - Noise: same rule, and additionally requires enable.
- Mix:
  - Left sum = sum of channel levels whose L-enable is set; right likewise. Range 0..45, 6 bits.
  - audio_x = sum << SAMPLE_SHIFT, registered; 1 cycle latency from level change to output.
- Reset values: all registers 0, counters 0, step 0, LFSR 0x7FFF, audio_l = audio_r = 0, active = 0.
- Reset asserted mid-note silences the outputs on the next cycle.

Decomposition:
- sv_sound_pkg:
  - register offset constants (SQ1_BASE = 6'h10, SQ2_BASE = 6'h14, NOISE_BASE = 6'h28)
  - duty table
  - LFSR seed 15'h7FFF
  - ctrl-field typedefs for square and noise
- Sub-module sv_sound_square: period counter, step counter, duty compare, length counter. Instantiated twice.
- Noise generator, prescaler and mixer stay inline.

Test Plan:
- Reset, then write ch1 period = 0x004, ctrl = 0xCF, length = 0x10, ce held high -> audio_l = audio_r = 0x3C00 for 5 ce out of every 8×5 = 40 ce; 0 otherwise.
- Ch1 length = 1 with LEN_DIV forced to 4 -> active[0] falls after 4 ce and audio returns to 0. Repeat with the length write landing on the len_tick cycle -> counter reloads, active stays set.
- Ch1 vol 15 L-only, ch2 vol 15 R-only, noise vol 15 L+R enabled in continuous mode, all generator outputs high -> audio_l = audio_r = 30<<10 = 0x7800. With all three levels on L, audio_l = 45<<10 = 0xB400.
- Noise sel = 0, short mode = 0, from reset -> LFSR after 1 shift = 0x3FFF, after 8×16 ce matches reference 15-bit sequence. Short mode -> period 127 shifts.
- Period written as 0 while running -> output held 0. Period changed mid-count -> old count completes before the new period is used.
- Reset asserted while all channels sound -> the next cycle has audio = 0, active = 0, LFSR = 0x7FFF.

Source files
------------

// File: rtl/sv_sound_pkg.sv
// Shared constants, register field layouts and the duty table for the sound block.
package sv_sound_pkg;

  localparam logic [5:0]  SQ1_BASE   = 6'h10;
  localparam logic [5:0]  SQ2_BASE   = 6'h14;
  localparam logic [5:0]  NOISE_BASE = 6'h28;
  localparam logic [14:0] LFSR_SEED  = 15'h7FFF;

  typedef struct packed {
    logic       r_en;
    logic       l_en;
    logic [1:0] duty;
    logic [3:0] vol;
  } sq_ctrl_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] vol;
  } nz_cfg_t;

  typedef struct packed {
    logic enable;
    logic r_en;
    logic l_en;
    logic cont;
    logic short_mode;
  } nz_ctrl_t;

  // Number of high steps out of 8 for each duty code.
  function automatic logic [3:0] duty_len(input logic [1:0] duty);
    unique case (duty)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd6;
    endcase
  endfunction

endpackage

// File: rtl/sv_sound_square.sv
// One duty-cycle square channel: register bank, period/step counters and length counter.
module sv_sound_square
  import sv_sound_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       len_tick,
  input  logic       wr_en,
  input  logic [1:0] wr_off,
  input  logic [7:0] din,
  output logic [3:0] level,
  output logic       l_en,
  output logic       r_en,
  output logic       active
);

  logic [10:0] period_q, period_d;
  logic [10:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  len_q, len_d;
  logic        active_q, active_d;
  sq_ctrl_t    ctrl_q, ctrl_d;
  logic        gen_high;

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    len_d    = len_q;
    active_d = active_q;
    ctrl_d   = ctrl_q;

    // The period register is only sampled at reload, so a write lets the current count finish.
    if (ce && period_q != '0) begin
      if (cnt_q == '0) begin
        cnt_d  = period_q;
        step_d = step_q + 3'd1;
      end else begin
        cnt_d = cnt_q - 11'd1;
      end
    end

    if (len_tick && active_q && len_q != '0) begin
      len_d = len_q - 8'd1;
      if (len_q == 8'd1) active_d = 1'b0;
    end

    if (wr_en) begin
      unique case (wr_off)
        2'd0: period_d[7:0]  = din;
        2'd1: period_d[10:8] = din[2:0];
        2'd2: ctrl_d         = sq_ctrl_t'(din);
        default: begin
          len_d    = din;
          active_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      len_q    <= '0;
      active_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      len_q    <= len_d;
      active_q <= active_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign gen_high = (period_q != '0) && ({1'b0, step_q} < duty_len(ctrl_q.duty));
  assign level    = (active_q && gen_high) ? ctrl_q.vol : 4'd0;
  assign l_en     = ctrl_q.l_en;
  assign r_en     = ctrl_q.r_en;
  assign active   = active_q;

endmodule

// File: rtl/sv_sound.sv
// Sound register window: two square channels, LFSR noise, length prescaler and L/R mixer.
module sv_sound
  import sv_sound_pkg::*;
#(
  parameter int LEN_DIV      = 16384,
  parameter int SAMPLE_SHIFT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        cs,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [7:0]  din,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic [2:0]  active
);

  localparam logic [13:0] PRE_LAST = 14'(LEN_DIV - 1);
  localparam logic [5:0]  NZ_LEN   = NOISE_BASE + 6'd1;
  localparam logic [5:0]  NZ_CTRL  = NOISE_BASE + 6'd2;

  logic        wr;
  logic        len_tick;
  logic [13:0] pre_q, pre_d;
  logic [3:0]  sq1_level, sq2_level, nz_level;
  logic        sq1_l, sq1_r, sq2_l, sq2_r, sq1_act, sq2_act;

  nz_cfg_t     nz_cfg_q, nz_cfg_d;
  nz_ctrl_t    nz_ctrl_q, nz_ctrl_d;
  logic [7:0]  nz_len_q, nz_len_d;
  logic        nz_active_q, nz_active_d;
  logic [17:0] nz_cnt_q, nz_cnt_d;
  logic [14:0] lfsr_q, lfsr_d, lfsr_next;
  logic        fb;

  logic [5:0]  sum_l, sum_r;
  logic [15:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;

  assign wr       = cs && we;
  assign len_tick = ce && (pre_q == PRE_LAST);

  sv_sound_square u_sq1 (
    .clk(clk), .reset(reset), .ce(ce), .len_tick(len_tick),
    .wr_en(wr && addr[5:2] == SQ1_BASE[5:2]), .wr_off(addr[1:0]), .din(din),
    .level(sq1_level), .l_en(sq1_l), .r_en(sq1_r), .active(sq1_act)
  );

  sv_sound_square u_sq2 (
    .clk(clk), .reset(reset), .ce(ce), .len_tick(len_tick),
    .wr_en(wr && addr[5:2] == SQ2_BASE[5:2]), .wr_off(addr[1:0]), .din(din),
    .level(sq2_level), .l_en(sq2_l), .r_en(sq2_r), .active(sq2_act)
  );

  always_comb begin
    fb        = lfsr_q[0] ^ lfsr_q[1];
    lfsr_next = {fb, lfsr_q[14:1]};
    if (nz_ctrl_q.short_mode) lfsr_next[6] = fb;
  end

  always_comb begin
    pre_d       = pre_q;
    nz_cfg_d    = nz_cfg_q;
    nz_ctrl_d   = nz_ctrl_q;
    nz_len_d    = nz_len_q;
    nz_active_d = nz_active_q;
    nz_cnt_d    = nz_cnt_q;
    lfsr_d      = lfsr_q;

    if (ce) pre_d = (pre_q == PRE_LAST) ? 14'd0 : pre_q + 14'd1;

    // sel 15 overflows the 18-bit reload to 0, i.e. the LFSR shifts on every ce.
    if (ce) begin
      if (nz_cnt_q == '0) begin
        nz_cnt_d = 18'd8 << nz_cfg_q.sel;
        lfsr_d   = lfsr_next;
      end else begin
        nz_cnt_d = nz_cnt_q - 18'd1;
      end
    end

    if (len_tick && nz_active_q && !nz_ctrl_q.cont && nz_len_q != '0) begin
      nz_len_d = nz_len_q - 8'd1;
      if (nz_len_q == 8'd1) nz_active_d = 1'b0;
    end

    if (wr) begin
      if (addr == NOISE_BASE) nz_cfg_d = nz_cfg_t'(din);
      if (addr == NZ_LEN) begin
        nz_len_d    = din;
        nz_active_d = 1'b1;
      end
      if (addr == NZ_CTRL) begin
        nz_ctrl_d = nz_ctrl_t'(din[4:0]);
        if (!din[4]) lfsr_d = LFSR_SEED;
      end
    end
  end

  assign nz_level = (nz_active_q && nz_ctrl_q.enable && !lfsr_q[0]) ? nz_cfg_q.vol : 4'd0;

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    if (sq1_l)           sum_l = sum_l + 6'(sq1_level);
    if (sq2_l)           sum_l = sum_l + 6'(sq2_level);
    if (nz_ctrl_q.l_en)  sum_l = sum_l + 6'(nz_level);
    if (sq1_r)           sum_r = sum_r + 6'(sq1_level);
    if (sq2_r)           sum_r = sum_r + 6'(sq2_level);
    if (nz_ctrl_q.r_en)  sum_r = sum_r + 6'(nz_level);
    audio_l_d = 16'(sum_l) << SAMPLE_SHIFT;
    audio_r_d = 16'(sum_r) << SAMPLE_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q       <= '0;
      nz_cfg_q    <= '0;
      nz_ctrl_q   <= '0;
      nz_len_q    <= '0;
      nz_active_q <= 1'b0;
      nz_cnt_q    <= '0;
      lfsr_q      <= LFSR_SEED;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
    end else begin
      pre_q       <= pre_d;
      nz_cfg_q    <= nz_cfg_d;
      nz_ctrl_q   <= nz_ctrl_d;
      nz_len_q    <= nz_len_d;
      nz_active_q <= nz_active_d;
      nz_cnt_q    <= nz_cnt_d;
      lfsr_q      <= lfsr_d;
      audio_l_q   <= audio_l_d;
      audio_r_q   <= audio_r_d;
    end
  end

  assign audio_l = audio_l_q;
  assign audio_r = audio_r_q;
  assign active  = {nz_active_q, sq2_act, sq1_act};

endmodule
